uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Control and buffer stage for the UART receiver. Owns the active RX configuration
//  (prescaler, PAR_EN, PAR_TYP) and applies host updates only between frames. Tracks
//  frame activity on the serial line. Captures each received byte plus error flags
//  into a FIFO drained by a valid/ready consumer.
// PARAMETERS
//  DATA_WIDTH   8  receiver data width
//  SCALE_WIDTH  6  prescaler width
//  FIFO_DEPTH   4  entries, power of 2, >=2
//  TO_WIDTH    10  frame-timeout counter width; must hold 63*12
// PORTS
//  clk           in   1           single clock, the UART_RX oversampling clock
//  reset         in   1           asynchronous, active-high
//  rx_in         in   1           serial line, same net as UART_RX RX_IN; async, idle high
//  cfg_wr        in   1           host config write strobe, one cycle
//  cfg_par_en    in   1           requested parity enable
//  cfg_par_typ   in   1           requested parity type (0 even, 1 odd)
//  cfg_prescale  in   SCALE_WIDTH requested oversampling ratio
//  cfg_rej       out  1           pulse: write rejected (prescale <4)
//  cfg_pend      out  1           accepted write waiting for an idle line
//  rx_prescaler  out  SCALE_WIDTH active config to UART_RX
//  rx_par_en     out  1           active config to UART_RX
//  rx_par_typ    out  1           active config to UART_RX
//  rx_p_data     in   DATA_WIDTH  UART_RX P_DATA
//  rx_data_valid in   1           UART_RX data_valid pulse
//  rx_par_err    in   1           UART_RX Parity_Error pulse
//  rx_stp_err    in   1           UART_RX Stop_Error pulse
//  rd_valid      out  1           FIFO head valid
//  rd_ready      in   1           consumer accepts head
//  rd_data       out  DATA_WIDTH  head byte
//  rd_par_err    out  1           head flag
//  rd_stp_err    out  1           head flag
//  ovf           out  1           sticky overflow
//  ovf_clr       in   1           clears ovf
//  busy          out  1           frame in progress (state BUSY)
// BEHAVIOUR
//  Reset: rx_prescaler=8, rx_par_en=0, rx_par_typ=0. All other outputs 0. FIFO empty. State IDLE.
//  rx_in passes through a 2-FF synchroniser, reset value 1. A start is a sync'd 1->0 edge.
//  FSM states:
//   IDLE: start edge -> BUSY; else if cfg_pend -> CFG. A start edge has priority over CFG.
//   BUSY: load timeout = prescale*(10+par_en+1 guard). Exit to IDLE on any frame event
//     (valid|par_err|stp_err) or when the timeout reaches 0. Falling edges are ignored.
//   CFG: one cycle. Copy the pending regs to the rx_* outputs and clear cfg_pend -> IDLE.
//     A start edge in this cycle goes straight to BUSY.
//  cfg_wr with prescale<4: cfg_rej pulses the next cycle; pending regs are unchanged.
//  A valid cfg_wr overwrites the pending regs (last write wins) and sets cfg_pend.
//  A cfg_wr in the same cycle as CFG is taken as a new pending write.
//  Frame event: one push per cycle. Entry = {stp_err, par_err, p_data}, with the flags ORed.
//   Data is pushed even on error.
//  FIFO: registered outputs; rd_* show the head when rd_valid=1.
//   Pop happens on rd_valid & rd_ready.
//   Push when full: entry dropped, ovf set. Push and pop in the same cycle when full:
//    both succeed, no ovf.
//   ovf_clr together with a new overflow: set wins.
//  Latency: event at cycle N -> rd_valid at N+1 when the FIFO was empty.
//  Pointers are log2(DEPTH)+1 bits with a wrap bit. Full and empty come from the pointer compare.
//  Reset asserted mid-frame: everything returns to reset values and the FIFO is flushed.
// CONFIGURATION
//  UART_RX_ERR_CNT_EN defined: adds outputs par_err_cnt[7:0], stp_err_cnt[7:0], to_cnt[7:0].
//   Each is a saturating count of parity errors, stop errors, and BUSY exits by timeout.
//   All are cleared by the input cnt_clr. A cnt_clr and an increment in the same cycle:
//   clear wins.
//  Undefined: none of these ports or counters exist. There is no behaviour change otherwise.
// STRUCTURE
//  Package uart_rx_pkg: DATA_WIDTH, SCALE_WIDTH, state enum {IDLE,BUSY,CFG},
//   struct rx_entry_t {stp_err, par_err, data}, constant PRESCALE_MIN=4, PRESCALE_RST=8.
//  Sub-module uart_rx_fifo (sync FIFO of rx_entry_t with an ovf flag). The FSM and config
//   live in the top level.
// TESTING
//  1. Reset, then frame 0xBA with no parity, prescale 8 -> one entry 0xBA, flags 0.
//     busy is high for the frame duration.
//  2. cfg_wr(par_en=1, typ=0, ps=8) mid-frame -> cfg_pend=1. rx_* unchanged until the
//     event, then updated 2 cycles after.
//  3. Bad-parity frame 0xE4 -> entry 0xE4 with rd_par_err=1, and par_err_cnt=1 with _EN.
//  4. Start edge with the line held low and no event -> BUSY exits after 8*11 cycles.
//     No push; to_cnt=1.
//  5. rd_ready=0, 5 frames into depth 4 -> entries 1-4 are kept and ovf=1.
//     ovf_clr -> ovf=0.
//  6. cfg_wr with ps=3 -> cfg_rej pulses and cfg_pend stays 0. Reset mid-frame -> all
//     outputs return to reset values.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared widths, FSM states and FIFO entry type for the UART receive control stage
package uart_rx_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int SCALE_WIDTH = 6;

    localparam logic [SCALE_WIDTH-1:0] PRESCALE_MIN = SCALE_WIDTH'(4);
    localparam logic [SCALE_WIDTH-1:0] PRESCALE_RST = SCALE_WIDTH'(8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        CFG  = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic                  stp_err;
        logic                  par_err;
        logic [DATA_WIDTH-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous FIFO of received entries with sticky overflow flag
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      i_push,
    input  rx_entry_t i_push_entry,
    input  logic      i_pop_ready,
    input  logic      i_ovf_clr,
    output logic      o_valid,
    output rx_entry_t o_head,
    output logic      o_ovf
);

    localparam int AW = $clog2(DEPTH);

    rx_entry_t   r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_ovf;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push_ok;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop     = !w_empty && i_pop_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push_ok = i_push && (!w_full || w_pop);

    // Pointer advance and overflow flag; a new overflow beats a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_push && !w_push_ok)
                r_ovf <= 1'b1;
            else if (i_ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    // Entry storage; only slots between the pointers are ever presented.
    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_entry;
    end

    assign o_valid = !w_empty;
    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART RX config/activity FSM and result buffer; UART_RX_ERR_CNT_EN adds error counters
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TO_WIDTH   = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_in,
    input  logic                   cfg_wr,
    input  logic                   cfg_par_en,
    input  logic                   cfg_par_typ,
    input  logic [SCALE_WIDTH-1:0] cfg_prescale,
    output logic                   cfg_rej,
    output logic                   cfg_pend,
    output logic [SCALE_WIDTH-1:0] rx_prescaler,
    output logic                   rx_par_en,
    output logic                   rx_par_typ,
    input  logic [DATA_WIDTH-1:0]  rx_p_data,
    input  logic                   rx_data_valid,
    input  logic                   rx_par_err,
    input  logic                   rx_stp_err,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_par_err,
    output logic                   rd_stp_err,
    output logic                   ovf,
    input  logic                   ovf_clr,
`ifdef UART_RX_ERR_CNT_EN
    input  logic                   cnt_clr,
    output logic [7:0]             par_err_cnt,
    output logic [7:0]             stp_err_cnt,
    output logic [7:0]             to_cnt,
`endif
    output logic                   busy
);

    logic                   r_rx_meta;
    logic                   r_rx_sync;
    logic                   r_rx_prev;
    rx_state_e              r_state;
    rx_state_e              w_state_nxt;
    logic [TO_WIDTH-1:0]    r_timer;
    logic [SCALE_WIDTH-1:0] r_pend_ps;
    logic                   r_pend_par_en;
    logic                   r_pend_par_typ;
    logic                   r_cfg_pend;
    logic                   r_cfg_rej;
    logic [SCALE_WIDTH-1:0] r_rx_ps;
    logic                   r_rx_par_en;
    logic                   r_rx_par_typ;

    logic                   w_start;
    logic                   w_ev;
    logic                   w_cfg_ok;
    logic                   w_load_to;
    logic                   w_timeout;
    logic                   w_apply_cfg;
    logic [SCALE_WIDTH-1:0] w_ps_eff;
    logic                   w_par_eff;
    logic [TO_WIDTH-1:0]    w_to_load;
    rx_entry_t              w_entry;
    rx_entry_t              w_head;

    assign w_start  = r_rx_prev && !r_rx_sync;
    assign w_ev     = rx_data_valid || rx_par_err || rx_stp_err;
    assign w_cfg_ok = cfg_wr && (cfg_prescale >= PRESCALE_MIN);
    // Leaving CFG straight into a frame must time out with the config being applied.
    assign w_ps_eff  = (r_state == CFG) ? r_pend_ps : r_rx_ps;
    assign w_par_eff = (r_state == CFG) ? r_pend_par_en : r_rx_par_en;
    // Frame length in oversampled ticks: start + 8 data + stop + guard, plus parity.
    assign w_to_load = TO_WIDTH'(w_ps_eff) * (w_par_eff ? TO_WIDTH'(12) : TO_WIDTH'(11));

    // Line synchroniser plus one stage of history for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_in;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Next-state logic: start edge beats a pending config, frame events end BUSY early.
    always_comb begin
        w_state_nxt = r_state;
        w_load_to   = 1'b0;
        w_timeout   = 1'b0;
        w_apply_cfg = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = BUSY;
                    w_load_to   = 1'b1;
                end else if (r_cfg_pend) begin
                    w_state_nxt = CFG;
                end
            end
            BUSY: begin
                if (w_ev) begin
                    w_state_nxt = IDLE;
                end else if (r_timer <= TO_WIDTH'(1)) begin
                    w_state_nxt = IDLE;
                    w_timeout   = 1'b1;
                end
            end
            CFG: begin
                w_apply_cfg = 1'b1;
                if (w_start) begin
                    w_state_nxt = BUSY;
                    w_load_to   = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register and frame timeout down-counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_to)
                r_timer <= w_to_load;
            else if (r_state == BUSY && r_timer != '0)
                r_timer <= r_timer - 1'b1;
        end
    end

    // Host config: capture pending write (last wins), flag rejects, apply between frames.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_ps      <= PRESCALE_RST;
            r_pend_par_en  <= 1'b0;
            r_pend_par_typ <= 1'b0;
            r_cfg_pend     <= 1'b0;
            r_cfg_rej      <= 1'b0;
            r_rx_ps        <= PRESCALE_RST;
            r_rx_par_en    <= 1'b0;
            r_rx_par_typ   <= 1'b0;
        end else begin
            r_cfg_rej <= cfg_wr && !w_cfg_ok;
            if (w_cfg_ok) begin
                r_pend_ps      <= cfg_prescale;
                r_pend_par_en  <= cfg_par_en;
                r_pend_par_typ <= cfg_par_typ;
                r_cfg_pend     <= 1'b1;
            end else if (w_apply_cfg) begin
                r_cfg_pend <= 1'b0;
            end
            if (w_apply_cfg) begin
                r_rx_ps      <= r_pend_ps;
                r_rx_par_en  <= r_pend_par_en;
                r_rx_par_typ <= r_pend_par_typ;
            end
        end
    end

    assign w_entry = {rx_stp_err, rx_par_err, rx_p_data};

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_ev),
        .i_push_entry (w_entry),
        .i_pop_ready  (rd_ready),
        .i_ovf_clr    (ovf_clr),
        .o_valid      (rd_valid),
        .o_head       (w_head),
        .o_ovf        (ovf)
    );

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] r_par_cnt;
    logic [7:0] r_stp_cnt;
    logic [7:0] r_to_cnt;

    // Saturating statistics; clear takes priority over a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par_cnt <= '0;
            r_stp_cnt <= '0;
            r_to_cnt  <= '0;
        end else if (cnt_clr) begin
            r_par_cnt <= '0;
            r_stp_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            if (rx_par_err && r_par_cnt != 8'hFF)
                r_par_cnt <= r_par_cnt + 1'b1;
            if (rx_stp_err && r_stp_cnt != 8'hFF)
                r_stp_cnt <= r_stp_cnt + 1'b1;
            if (w_timeout && r_to_cnt != 8'hFF)
                r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign par_err_cnt = r_par_cnt;
    assign stp_err_cnt = r_stp_cnt;
    assign to_cnt      = r_to_cnt;
`endif

    assign cfg_rej      = r_cfg_rej;
    assign cfg_pend     = r_cfg_pend;
    assign rx_prescaler = r_rx_ps;
    assign rx_par_en    = r_rx_par_en;
    assign rx_par_typ   = r_rx_par_typ;
    assign rd_data      = w_head.data;
    assign rd_par_err   = w_head.par_err;
    assign rd_stp_err   = w_head.stp_err;
    assign busy         = (r_state == BUSY);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl; UART_RX_ERR_CNT_EN enables counter checks
module tb_uart_rx_ctrl;
    import uart_rx_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   rx_in;
    logic                   cfg_wr;
    logic                   cfg_par_en;
    logic                   cfg_par_typ;
    logic [SCALE_WIDTH-1:0] cfg_prescale;
    logic                   cfg_rej;
    logic                   cfg_pend;
    logic [SCALE_WIDTH-1:0] rx_prescaler;
    logic                   rx_par_en;
    logic                   rx_par_typ;
    logic [DATA_WIDTH-1:0]  rx_p_data;
    logic                   rx_data_valid;
    logic                   rx_par_err;
    logic                   rx_stp_err;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   rd_par_err;
    logic                   rd_stp_err;
    logic                   ovf;
    logic                   ovf_clr;
    logic                   busy;
`ifdef UART_RX_ERR_CNT_EN
    logic                   cnt_clr;
    logic [7:0]             par_err_cnt;
    logic [7:0]             stp_err_cnt;
    logic [7:0]             to_cnt;
`endif

    always #5 clk = ~clk;

    uart_rx_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .rx_in         (rx_in),
        .cfg_wr        (cfg_wr),
        .cfg_par_en    (cfg_par_en),
        .cfg_par_typ   (cfg_par_typ),
        .cfg_prescale  (cfg_prescale),
        .cfg_rej       (cfg_rej),
        .cfg_pend      (cfg_pend),
        .rx_prescaler  (rx_prescaler),
        .rx_par_en     (rx_par_en),
        .rx_par_typ    (rx_par_typ),
        .rx_p_data     (rx_p_data),
        .rx_data_valid (rx_data_valid),
        .rx_par_err    (rx_par_err),
        .rx_stp_err    (rx_stp_err),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .rd_par_err    (rd_par_err),
        .rd_stp_err    (rd_stp_err),
        .ovf           (ovf),
        .ovf_clr       (ovf_clr),
`ifdef UART_RX_ERR_CNT_EN
        .cnt_clr       (cnt_clr),
        .par_err_cnt   (par_err_cnt),
        .stp_err_cnt   (stp_err_cnt),
        .to_cnt        (to_cnt),
`endif
        .busy          (busy)
    );

    typedef struct {
        logic       v;
        logic       p;
        logic       s;
        logic [7:0] d;
        logic       kept;
        logic       exp_valid;
        logic       exp_ovf;
    } vec_t;

    int        n_checks = 0;
    int        n_fail   = 0;
    int        n_par    = 0;
    int        n_stp    = 0;
    int        n_to     = 0;
    rx_entry_t exp_q[$];
    vec_t      tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_ev(input logic v, input logic p, input logic s, input logic [7:0] d,
                            input logic kept);
        rx_data_valid = v;
        rx_par_err    = p;
        rx_stp_err    = s;
        rx_p_data     = d;
        if (kept)
            exp_q.push_back({s, p, d});
        if (p)
            n_par++;
        if (s)
            n_stp++;
        step();
        rx_data_valid = 1'b0;
        rx_par_err    = 1'b0;
        rx_stp_err    = 1'b0;
    endtask

    task automatic start_edge();
        rx_in = 1'b0;
        step(3);
        rx_in = 1'b1;
    endtask

    task automatic drain(input string name);
        rx_entry_t e;
        for (int k = 0; k < 16 && rd_valid; k++) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s extra: got entry %0h expected none", name, rd_data);
            end else begin
                e = exp_q.pop_front();
                chk({name, " data"}, 32'(rd_data), 32'(e.data));
                chk({name, " par"}, 32'(rd_par_err), 32'(e.par_err));
                chk({name, " stp"}, 32'(rd_stp_err), 32'(e.stp_err));
            end
            rd_ready = 1'b1;
            step();
            rd_ready = 1'b0;
        end
        chk({name, " empty"}, 32'(rd_valid), 32'd0);
        chk({name, " sb_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        tbl[0] = '{1'b0, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 8'h44, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1};

        reset = 1'b1; rx_in = 1'b1; cfg_wr = 1'b0; cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
        cfg_prescale = 6'd8; rx_p_data = 8'h00; rx_data_valid = 1'b0; rx_par_err = 1'b0;
        rx_stp_err = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0;
`ifdef UART_RX_ERR_CNT_EN
        cnt_clr = 1'b0;
`endif
        step(2);
        reset = 1'b0;
        step();
        chk("rst prescaler", 32'(rx_prescaler), 32'd8);
        chk("rst par_en", 32'(rx_par_en), 32'd0);
        chk("rst par_typ", 32'(rx_par_typ), 32'd0);
        chk("rst cfg_rej", 32'(cfg_rej), 32'd0);
        chk("rst cfg_pend", 32'(cfg_pend), 32'd0);
        chk("rst rd_valid", 32'(rd_valid), 32'd0);
        chk("rst rd_data", 32'(rd_data), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);

        // Clean frame 0xBA
        start_edge();
        chk("f1 busy start", 32'(busy), 32'd1);
        step(20);
        chk("f1 busy mid", 32'(busy), 32'd1);
        frame_ev(1'b1, 1'b0, 1'b0, 8'hBA, 1'b1);
        chk("f1 busy end", 32'(busy), 32'd0);
        chk("f1 latency", 32'(rd_valid), 32'd1);
        drain("f1");

        // Line held low, no frame event: timeout after 8*11 cycles
        rx_in = 1'b0;
        cnt = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (busy)
                cnt++;
            else if (cnt > 0)
                break;
        end
        n_to++;
        chk("to busy cycles", 32'(cnt), 32'd88);
        chk("to no push", 32'(rd_valid), 32'd0);
`ifdef UART_RX_ERR_CNT_EN
        chk("to_cnt", 32'(to_cnt), 32'(n_to));
`endif
        rx_in = 1'b1;
        step(3);

        // Config write mid-frame, applied two cycles after the frame event
        start_edge();
        cfg_wr = 1'b1; cfg_par_en = 1'b1; cfg_par_typ = 1'b0; cfg_prescale = 6'd8;
        step();
        cfg_wr = 1'b0;
        chk("c2 pend", 32'(cfg_pend), 32'd1);
        chk("c2 par_en held", 32'(rx_par_en), 32'd0);
        step(5);
        chk("c2 par_en busy", 32'(rx_par_en), 32'd0);
        frame_ev(1'b1, 1'b1, 1'b0, 8'hE4, 1'b1);
        chk("c2 par_en ev+0", 32'(rx_par_en), 32'd0);
        step();
        chk("c2 par_en ev+1", 32'(rx_par_en), 32'd0);
        step();
        chk("c2 par_en ev+2", 32'(rx_par_en), 32'd1);
        chk("c2 pend cleared", 32'(cfg_pend), 32'd0);
        chk("c2 prescaler", 32'(rx_prescaler), 32'd8);
        drain("f3");
`ifdef UART_RX_ERR_CNT_EN
        chk("par_err_cnt f3", 32'(par_err_cnt), 32'(n_par));
`endif

        // Table: events with no consumer, fill then overflow
        for (int i = 0; i < 6; i++) begin
            frame_ev(tbl[i].v, tbl[i].p, tbl[i].s, tbl[i].d, tbl[i].kept);
            chk($sformatf("tbl%0d rd_valid", i), 32'(rd_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d ovf", i), 32'(ovf), 32'(tbl[i].exp_ovf));
        end
`ifdef UART_RX_ERR_CNT_EN
        chk("par_err_cnt tbl", 32'(par_err_cnt), 32'(n_par));
        chk("stp_err_cnt tbl", 32'(stp_err_cnt), 32'(n_stp));
`endif
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf cleared", 32'(ovf), 32'd0);

        // Push and pop together while full: both succeed, no overflow
        chk("full head", 32'(rd_data), 32'(exp_q[0].data));
        void'(exp_q.pop_front());
        rd_ready = 1'b1;
        frame_ev(1'b1, 1'b0, 1'b0, 8'h66, 1'b1);
        rd_ready = 1'b0;
        chk("pushpop ovf", 32'(ovf), 32'd0);
        drain("pp");

        // Overflow coinciding with ovf_clr: set wins
        for (int i = 0; i < 4; i++)
            frame_ev(1'b1, 1'b0, 1'b0, 8'(8'hA0 + i), 1'b1);
        ovf_clr = 1'b1;
        frame_ev(1'b1, 1'b0, 1'b0, 8'hAF, 1'b0);
        ovf_clr = 1'b0;
        chk("ovf set wins", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf clr2", 32'(ovf), 32'd0);
        drain("sw");

        // Accepted idle write, then a rejected write that must not disturb anything
        cfg_wr = 1'b1; cfg_par_en = 1'b1; cfg_par_typ = 1'b1; cfg_prescale = 6'd12;
        step();
        cfg_wr = 1'b0;
        chk("c6 pend", 32'(cfg_pend), 32'd1);
        step(2);
        chk("c6 prescaler", 32'(rx_prescaler), 32'd12);
        chk("c6 par_typ", 32'(rx_par_typ), 32'd1);
        cfg_wr = 1'b1; cfg_par_en = 1'b0; cfg_par_typ = 1'b0; cfg_prescale = 6'd3;
        step();
        cfg_wr = 1'b0;
        chk("rej pulse", 32'(cfg_rej), 32'd1);
        chk("rej pend", 32'(cfg_pend), 32'd0);
        step();
        chk("rej pulse end", 32'(cfg_rej), 32'd0);
        step(3);
        chk("rej prescaler", 32'(rx_prescaler), 32'd12);
        chk("rej par_en", 32'(rx_par_en), 32'd1);

`ifdef UART_RX_ERR_CNT_EN
        cnt_clr = 1'b1;
        frame_ev(1'b1, 1'b1, 1'b1, 8'h77, 1'b1);
        cnt_clr = 1'b0;
        chk("cnt clr wins par", 32'(par_err_cnt), 32'd0);
        chk("cnt clr wins stp", 32'(stp_err_cnt), 32'd0);
        chk("cnt clr to", 32'(to_cnt), 32'd0);
        drain("cc");
`endif

        // Reset in the middle of a frame with data buffered and a write pending
        frame_ev(1'b1, 1'b0, 1'b0, 8'h5A, 1'b1);
        start_edge();
        chk("mr busy", 32'(busy), 32'd1);
        cfg_wr = 1'b1; cfg_prescale = 6'd20;
        step();
        cfg_wr = 1'b0;
        chk("mr pend", 32'(cfg_pend), 32'd1);
        reset = 1'b1;
        #1;
        exp_q.delete();
        chk("mr busy rst", 32'(busy), 32'd0);
        chk("mr rd_valid", 32'(rd_valid), 32'd0);
        chk("mr rd_data", 32'(rd_data), 32'd0);
        chk("mr pend rst", 32'(cfg_pend), 32'd0);
        chk("mr prescaler", 32'(rx_prescaler), 32'd8);
        chk("mr par_en", 32'(rx_par_en), 32'd0);
        chk("mr par_typ", 32'(rx_par_typ), 32'd0);
        chk("mr ovf", 32'(ovf), 32'd0);
        step(2);
        reset = 1'b0;
        step(2);
        chk("post busy", 32'(busy), 32'd0);
        chk("post rd_valid", 32'(rd_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
